// File: rtl/reg_file_2r1w.sv
// Register file: DEPTH x WIDTH storage, one synchronous write port, two combinational read ports.
// Optional hardwired-zero word 0, optional write-to-read bypass, synchronous clear-all.
module reg_file_2r1w #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned ZERO_R0 = 1,
    parameter int unsigned BYPASS  = 0
) (
    input  logic              clk,
    input  logic              res,
    input  logic              we,
    input  logic              clr,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b
);

    localparam int unsigned NUM_RD = 2;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic              wr_valid_c;
    logic              byp_en_c;
    logic [ADDR_W-1:0] raddr_c [NUM_RD];
    logic [WIDTH-1:0]  rdata_c [NUM_RD];

    // Word 0 is never writable when hardwired to zero, so its flops stay at reset value.
    assign wr_valid_c = (32'(waddr) < DEPTH) && !((ZERO_R0 != 0) && (waddr == '0));
    assign byp_en_c   = (BYPASS != 0) && we && !clr && res && wr_valid_c;

    // Per-word hold/load selection; clear wins over write.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (clr) begin
                mem_d[i] = '0;
            end else if (we && wr_valid_c && (32'(waddr) == i)) begin
                mem_d[i] = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign raddr_c[0] = raddr_a;
    assign raddr_c[1] = raddr_b;

    // Combinational read mux per port; reset forces zero even on the bypass path.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        always_comb begin
            rdata_c[p] = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (32'(raddr_c[p]) == i) begin
                    rdata_c[p] = mem_q[i];
                end
            end
            if ((ZERO_R0 != 0) && (raddr_c[p] == '0)) begin
                rdata_c[p] = '0;
            end
            if (byp_en_c && (raddr_c[p] == waddr)) begin
                rdata_c[p] = wdata;
            end
            if (!res) begin
                rdata_c[p] = '0;
            end
        end
    end

    assign rdata_a = rdata_c[0];
    assign rdata_b = rdata_c[1];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: four configurations share one stimulus stream and are
// checked every cycle against an array model, plus directed literal expectations.
module tb_reg_file_2r1w;

    localparam int NCFG = 4;
    // Configurations: 0 default, 1 no zero word, 2 DEPTH=6, 3 bypass on
    localparam int CFG_DEPTH [NCFG] = '{8, 8, 6, 8};
    localparam int CFG_ZERO  [NCFG] = '{1, 0, 1, 1};
    localparam int CFG_BYP   [NCFG] = '{0, 0, 0, 1};

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       we = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] raddr_a = '0;
    logic [2:0] raddr_b = '0;
    logic [7:0] rd_a [NCFG];
    logic [7:0] rd_b [NCFG];

    logic [7:0] mem [NCFG][8];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_2r1w #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_R0(1), .BYPASS(0)) u_d0 (
        .clk(clk), .res(res), .we(we), .clr(clr), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[0]), .rdata_b(rd_b[0]));
    reg_file_2r1w #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_R0(0), .BYPASS(0)) u_nz (
        .clk(clk), .res(res), .we(we), .clr(clr), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[1]), .rdata_b(rd_b[1]));
    reg_file_2r1w #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .ZERO_R0(1), .BYPASS(0)) u_d6 (
        .clk(clk), .res(res), .we(we), .clr(clr), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[2]), .rdata_b(rd_b[2]));
    reg_file_2r1w #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_R0(1), .BYPASS(1)) u_bp (
        .clk(clk), .res(res), .we(we), .clr(clr), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[3]), .rdata_b(rd_b[3]));

    function automatic bit wr_ok(int k, logic [2:0] a);
        return (int'(a) < CFG_DEPTH[k]) && !(CFG_ZERO[k] != 0 && a == 3'd0);
    endfunction

    // What a read port must show right now, from the stored words and current inputs.
    function automatic logic [7:0] exp_read(int k, logic [2:0] a);
        if (!res) return 8'h00;
        if (CFG_BYP[k] != 0 && we && !clr && wr_ok(k, waddr) && a == waddr) return wdata;
        if (int'(a) >= CFG_DEPTH[k]) return 8'h00;
        if (CFG_ZERO[k] != 0 && a == 3'd0) return 8'h00;
        return mem[k][a];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    // Compute the words after the coming edge, then commit them at the edge.
    task automatic tick();
        logic [7:0] nxt [NCFG][8];
        for (int k = 0; k < NCFG; k++) begin
            for (int i = 0; i < 8; i++) begin
                nxt[k][i] = mem[k][i];
                if (!res || clr) nxt[k][i] = 8'h00;
                else if (we && wr_ok(k, waddr) && int'(waddr) == i) nxt[k][i] = wdata;
            end
        end
        @(posedge clk);
        mem = nxt;
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("cyc_cfg%0d_a%0d", k, raddr_a), rd_a[k], exp_read(k, raddr_a));
            check($sformatf("cyc_cfg%0d_b%0d", k, raddr_b), rd_b[k], exp_read(k, raddr_b));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NCFG; k++)
            for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;

        // Reset held: every address reads 0 on every configuration
        #1 res = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            #1;
            check("rst_d0_a", rd_a[0], 8'h00);
            check("rst_nz_b", rd_b[1], 8'h00);
        end
        tick();
        tick();
        res = 1'b1;

        write(3'd3, 8'hA5);
        raddr_a = 3'd3; #1;
        check("wr_a5_addr3", rd_a[0], 8'hA5);

        // Hardwired zero vs plain word 0
        write(3'd0, 8'hFF);
        raddr_a = 3'd0; #1;
        check("zero_r0_on", rd_a[0], 8'h00);
        check("zero_r0_off", rd_a[1], 8'hFF);

        // Out-of-range write on DEPTH=6 is dropped
        write(3'd7, 8'h3C);
        raddr_b = 3'd7; #1;
        check("oor_d6_b7", rd_b[2], 8'h00);
        check("inr_d0_b7", rd_b[0], 8'h3C);
        raddr_b = 3'd3; #1;
        check("oor_d6_keep3", rd_b[2], 8'hA5);

        // Bypass: new data visible before the edge only when enabled
        write(3'd2, 8'h11);
        we = 1'b1; waddr = 3'd2; wdata = 8'h22; raddr_a = 3'd2; #1;
        check("byp_pre_on", rd_a[3], 8'h22);
        check("byp_pre_off", rd_a[0], 8'h11);
        tick();
        we = 1'b0; #1;
        check("byp_post_on", rd_a[3], 8'h22);
        check("byp_post_off", rd_a[0], 8'h22);
        // Bypass never applies to the zero word
        we = 1'b1; waddr = 3'd0; wdata = 8'h77; raddr_a = 3'd0; #1;
        check("byp_zero_word", rd_a[3], 8'h00);
        tick();
        we = 1'b0;

        // Clear beats write
        for (int i = 1; i < 8; i++) write(3'(i), 8'(i));
        raddr_a = 3'd4; #1;
        check("fill_w4", rd_a[0], 8'h04);
        clr = 1'b1; we = 1'b1; waddr = 3'd4; wdata = 8'h99; #1;
        check("clr_blocks_byp", rd_a[3], 8'h04);
        tick();
        clr = 1'b0; we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i); #1;
            check("clr_all_nz_a", rd_a[1], 8'h00);
            check("clr_all_bp_b", rd_b[3], 8'h00);
        end

        // Back-to-back writes, then async reset in the middle of a write cycle
        for (int i = 0; i < 5; i++) write(3'(i), 8'h10 + 8'(i));
        raddr_a = 3'd3; #1;
        check("b2b_w3", rd_a[0], 8'h13);
        we = 1'b1; waddr = 3'd5; wdata = 8'h15; raddr_b = 3'd5;
        #2;
        res = 1'b0;
        for (int k = 0; k < NCFG; k++)
            for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;
        #1;
        check("async_drop_a", rd_a[0], 8'h00);
        check("async_drop_nz", rd_a[1], 8'h00);
        check("async_byp_b", rd_b[3], 8'h00);
        tick();
        res = 1'b1; we = 1'b0; #1;
        check("lost_write_w5", rd_b[1], 8'h00);
        check("lost_w3", rd_a[1], 8'h00);
        write(3'd6, 8'h16);
        write(3'd7, 8'h17);
        raddr_a = 3'd7; raddr_b = 3'd7; #1;
        check("resume_w7_a", rd_a[0], 8'h17);
        check("resume_w7_b", rd_b[0], 8'h17);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file for the memory unit: DEPTH words of WIDTH bits, one synchronous write port and two combinational read ports. It replaces stand-alone enable registers as the datapath's operand storage. It adds the following over a single enabled register:
- multiple words with address decode,
- a hardwired-zero location,
- optional write-to-read bypass,
- a synchronous clear-all.

## Interface
Parameters:
- WIDTH, default 8: bits per word (1..32).
- DEPTH, default 8: number of words (2..32). Does not need to be a power of two.
- ADDR_W, default 3: address width. Must satisfy 2^ADDR_W >= DEPTH.
- ZERO_R0, default 1: when 1, word 0 always reads as 0 and writes to it are discarded.
- BYPASS, default 0: when 1, a read of the word being written in the same cycle returns the new data combinationally.

Ports:
- clk, input, 1: clock. All state changes occur on its rising edge.
- res, input, 1: reset. Asynchronous and active-low. While 0, every stored word is 0.
- we, input, 1: write enable, sampled on the rising clk edge.
- clr, input, 1: synchronous clear-all, sampled on the rising clk edge.
- waddr, input, ADDR_W: write address.
- wdata, input, WIDTH: write data.
- raddr_a, input, ADDR_W: read address, port A.
- raddr_b, input, ADDR_W: read address, port B.
- rdata_a, output, WIDTH: read data, port A.
- rdata_b, output, WIDTH: read data, port B.

## Operation
- Storage is DEPTH words, each WIDTH bits, built from per-bit D flip-flops with a hold/load mux on each bit.
- res = 0 forces all words to 0 immediately, without waiting for clk.
  - It overrides we and clr.
  - While res = 0, rdata_a and rdata_b read 0 for every address. This includes the bypass case.
- On a rising edge with res = 1, exactly one of the following applies, in priority order:
  1. clr = 1: every word becomes 0. we is ignored.
  2. we = 1 and waddr is valid: word[waddr] is loaded with wdata. All other words hold.
  3. Otherwise: all words hold.
- A write address is valid when waddr < DEPTH, and, if ZERO_R0 = 1, also waddr != 0. Writes to invalid addresses are silently dropped.
- Reads are purely combinational: rdata_x = word[raddr_x].
  - raddr_x >= DEPTH reads 0.
  - With ZERO_R0 = 1, raddr_x = 0 reads 0.
- Bypass (BYPASS = 1 only): rdata_x = wdata when all of the following hold:
  - we = 1,
  - clr = 0,
  - res = 1,
  - waddr is a valid write address,
  - raddr_x = waddr.
- Bypass is never applied to an invalid write address. A read of such an address still returns 0.
- Both read ports are independent. Same address on both ports returns identical data.

## Timing
- Write latency, BYPASS = 0: data written at edge N is visible on the read ports just after edge N (same-cycle read returns the old value).
- Write latency, BYPASS = 1: data is visible combinationally during the cycle before edge N and remains stored afterwards.
- clr latency: after edge N, all words read 0.
- Reset assert is asynchronous. Outputs reach 0 without a clock edge.
- Reset deassert: the first edge that can write is the first rising clk after res rises.
- Reset mid-operation: a write in the same cycle that res falls is lost.
- No handshake. we and clr are single-cycle qualifiers and may be held high for back-to-back writes, one per cycle.
- Read path: address to data is combinational. There is no pipeline register.

## Test plan
1. Reset, DEPTH=8, WIDTH=8, ZERO_R0=1: hold res = 0 and read all addresses on both ports → all 0. Release res and write 0xA5 to address 3 → from the next cycle, rdata_a = 0xA5 when raddr_a = 3.
2. Zero register: we = 1, waddr = 0, wdata = 0xFF → raddr_a = 0 reads 0x00. With ZERO_R0 = 0, the same stimulus reads 0xFF.
3. Out of range: DEPTH = 6, write 0x3C to address 7 → raddr_b = 7 reads 0, and words 0..5 are unchanged.
4. Bypass:
   - BYPASS = 1: with word 2 = 0x11, drive we = 1, waddr = 2, wdata = 0x22, raddr_a = 2 → rdata_a = 0x22 before the edge and after it.
   - BYPASS = 0, same stimulus: rdata_a = 0x11 before the edge and 0x22 after it.
5. Clear priority: fill words 1..7 with 0x01..0x07, then drive clr = 1 together with we = 1, waddr = 4, wdata = 0x99 → after the edge, every word reads 0.
6. Async reset mid-stream: back-to-back writes of 0x10..0x17 to addresses 0..7. Pulse res low between edges → outputs drop to 0 immediately, and the write in that cycle is not stored.
